// File: rtl/lane_fifo_mux.sv
// lane_fifo_mux
//   An N-lane FIFO built on one shared simple-dual-port RAM. Lane storage
//   is addressed as {lane, ptr}. Each cycle allows one write and one read,
//   and each may target any lane. Every lane keeps its own write pointer,
//   read pointer, fill level and status flags, and can be flushed on its own.
//
//   Ports
//     clk, reset_n            clock (rising edge), asynchronous active-low reset
//     wr_en/wr_lane/wr_data   write request; wr_accept says whether it is taken
//     rd_req/rd_lane          read request; rd_accept says whether it is taken
//     rd_valid/rd_data/rd_data_lane  registered read result, 1-cycle latency
//     flush/flush_lane        synchronous clear of one lane
//     lane_empty/full/afull   registered per-lane status flags
//     lane_usedw              per-lane fill level, ADDR_WIDTH+1 bits per lane
//     drop_sel/drop_cnt       per-lane refused-write counter readout
//
//   Optional feature: define LANE_FIFO_DROP_CNT_EN to build 16-bit saturating
//   drop counters. When it is not defined, drop_cnt is tied to zero.
module lane_fifo_mux #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 9,
  parameter int N_LANES    = 4,
  parameter int LANE_BITS  = 2,
  parameter int AFULL_TH   = 480
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [LANE_BITS-1:0]             wr_lane,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             wr_accept,
  input  logic                             rd_req,
  input  logic [LANE_BITS-1:0]             rd_lane,
  output logic                             rd_accept,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [LANE_BITS-1:0]             rd_data_lane,
  input  logic                             flush,
  input  logic [LANE_BITS-1:0]             flush_lane,
  output logic [N_LANES-1:0]               lane_empty,
  output logic [N_LANES-1:0]               lane_full,
  output logic [N_LANES-1:0]               lane_afull,
  output logic [N_LANES*(ADDR_WIDTH+1)-1:0] lane_usedw,
  input  logic [LANE_BITS-1:0]             drop_sel,
  output logic [15:0]                      drop_cnt
);

  localparam int UW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [UW-1:0] FULL_LVL  = UW'(DEPTH);
  localparam logic [UW-1:0] AFULL_LVL = UW'(AFULL_TH);

  logic [DATA_WIDTH-1:0] mem_q [0:N_LANES*DEPTH-1];

  logic [ADDR_WIDTH-1:0] wptr_q  [N_LANES];
  logic [ADDR_WIDTH-1:0] wptr_d  [N_LANES];
  logic [ADDR_WIDTH-1:0] rptr_q  [N_LANES];
  logic [ADDR_WIDTH-1:0] rptr_d  [N_LANES];
  logic [UW-1:0]         usedw_q [N_LANES];
  logic [UW-1:0]         usedw_d [N_LANES];
  logic [N_LANES-1:0]    empty_q, empty_d, full_q, full_d, afull_q, afull_d;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [LANE_BITS-1:0]  rd_lane_q;

  logic wr_flushed, rd_flushed;
  logic [LANE_BITS+ADDR_WIDTH-1:0] waddr, raddr;

  assign wr_flushed = flush && (flush_lane == wr_lane);
  assign rd_flushed = flush && (flush_lane == rd_lane);

  // A full lane refuses writes and an empty lane refuses reads, even when the
  // other port frees or fills a slot in the same cycle. Because of this, one
  // RAM address is never read and written in the same cycle.
  assign wr_accept = wr_en && !full_q[wr_lane] && !wr_flushed;
  assign rd_accept = rd_req && !empty_q[rd_lane] && !rd_flushed;

  assign waddr = {wr_lane, wptr_q[wr_lane]};
  assign raddr = {rd_lane, rptr_q[rd_lane]};

  always_comb begin
    for (int unsigned i = 0; i < N_LANES; i++) begin
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      usedw_d[i] = usedw_q[i];
      if (flush && (flush_lane == LANE_BITS'(i))) begin
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
        usedw_d[i] = '0;
      end else begin
        if (wr_accept && (wr_lane == LANE_BITS'(i))) wptr_d[i] = wptr_q[i] + 1'b1;
        if (rd_accept && (rd_lane == LANE_BITS'(i))) rptr_d[i] = rptr_q[i] + 1'b1;
        case ({wr_accept && (wr_lane == LANE_BITS'(i)),
               rd_accept && (rd_lane == LANE_BITS'(i))})
          2'b10:   usedw_d[i] = usedw_q[i] + 1'b1;
          2'b01:   usedw_d[i] = usedw_q[i] - 1'b1;
          default: usedw_d[i] = usedw_q[i];
        endcase
      end
      empty_d[i] = (usedw_d[i] == '0);
      full_d[i]  = (usedw_d[i] == FULL_LVL);
      afull_d[i] = (usedw_d[i] >= AFULL_LVL);
    end
  end

  // RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[waddr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        usedw_q[i] <= '0;
      end
      empty_q    <= '1;
      full_q     <= '0;
      afull_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_lane_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
        usedw_q[i] <= usedw_d[i];
      end
      empty_q    <= empty_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= mem_q[raddr];
        rd_lane_q <= rd_lane;
      end
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_data_lane = rd_lane_q;
  assign lane_empty   = empty_q;
  assign lane_full    = full_q;
  assign lane_afull   = afull_q;

  always_comb begin
    lane_usedw = '0;
    for (int unsigned i = 0; i < N_LANES; i++)
      lane_usedw[i*UW +: UW] = usedw_q[i];
  end

`ifdef LANE_FIFO_DROP_CNT_EN
  logic [15:0] drop_q [N_LANES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_LANES; i++) drop_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
        if (flush && (flush_lane == LANE_BITS'(i)))
          drop_q[i] <= '0;
        else if (wr_en && !wr_accept && (wr_lane == LANE_BITS'(i)) && (drop_q[i] != '1))
          drop_q[i] <= drop_q[i] + 1'b1;
      end
    end
  end

  assign drop_cnt = drop_q[drop_sel];
`else
  logic unused_drop_sel;
  assign unused_drop_sel = ^drop_sel;
  assign drop_cnt        = '0;
`endif

endmodule

// File: tb/tb_lane_fifo_mux.sv
// Testbench for lane_fifo_mux. Stimulus issues directed requests and pushes
// each expected read word into a scoreboard queue. A separate monitor pops
// an entry and compares it whenever rd_valid is high.
module tb_lane_fifo_mux;
  localparam int DW = 40;
  localparam int AW = 9;
  localparam int NL = 4;
  localparam int LB = 2;
  localparam int DEPTH = 512;
  localparam int AFT = 480;

  logic clk = 1'b0;
  logic reset_n;
  logic wr_en, rd_req, flush;
  logic [LB-1:0] wr_lane, rd_lane, flush_lane, drop_sel, rd_data_lane;
  logic [DW-1:0] wr_data, rd_data;
  logic wr_accept, rd_accept, rd_valid;
  logic [NL-1:0] lane_empty, lane_full, lane_afull;
  logic [NL*(AW+1)-1:0] lane_usedw;
  logic [15:0] drop_cnt;

  lane_fifo_mux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_LANES(NL),
                  .LANE_BITS(LB), .AFULL_TH(AFT)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_lane(wr_lane), .wr_data(wr_data), .wr_accept(wr_accept),
    .rd_req(rd_req), .rd_lane(rd_lane), .rd_accept(rd_accept),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_data_lane(rd_data_lane),
    .flush(flush), .flush_lane(flush_lane),
    .lane_empty(lane_empty), .lane_full(lane_full), .lane_afull(lane_afull),
    .lane_usedw(lane_usedw), .drop_sel(drop_sel), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle_n = 0;

  logic [DW-1:0] mq [NL][$];          // per-lane model of stored words
  logic [DW+LB-1:0] sb [$];           // expected {lane, data} of read results
  int dropm [NL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid read result must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got lane %0d data %0h expected no read", rd_data_lane, rd_data);
      end else begin
        logic [DW+LB-1:0] e;
        e = sb.pop_front();
        if ({rd_data_lane, rd_data} !== e) begin
          errors++;
          $display("FAIL rd_data: got lane %0d data %0h expected lane %0d data %0h",
                   rd_data_lane, rd_data, e[DW+LB-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic status();
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("usedw[%0d]", i), 64'(lane_usedw[i*(AW+1) +: AW+1]), 64'(mq[i].size()));
      chk($sformatf("empty[%0d]", i), 64'(lane_empty[i]), 64'(mq[i].size() == 0));
      chk($sformatf("full[%0d]", i),  64'(lane_full[i]),  64'(mq[i].size() == DEPTH));
      chk($sformatf("afull[%0d]", i), 64'(lane_afull[i]), 64'(mq[i].size() >= AFT));
    end
  endtask

  // One clock cycle of stimulus. Call this just after a rising edge.
  task automatic cyc(input bit wen, input logic [LB-1:0] wl, input logic [DW-1:0] wd,
                     input bit rreq, input logic [LB-1:0] rl,
                     input bit fl = 1'b0, input logic [LB-1:0] fll = '0);
    bit ewa, era;
    logic [LB-1:0] ds;
    ds = LB'(cycle_n % NL);
    wr_en = wen; wr_lane = wl; wr_data = wd;
    rd_req = rreq; rd_lane = rl; flush = fl; flush_lane = fll; drop_sel = ds;
    #1;
    status();
`ifdef LANE_FIFO_DROP_CNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(dropm[ds]));
`else
    chk("drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    ewa = wen && (mq[wl].size() < DEPTH) && !(fl && fll == wl);
    era = rreq && (mq[rl].size() > 0) && !(fl && fll == rl);
    if (wen)  chk("wr_accept", 64'(wr_accept), 64'(ewa));
    if (rreq) chk("rd_accept", 64'(rd_accept), 64'(era));
    if (era) sb.push_back({rl, mq[rl].pop_front()});
    if (ewa) mq[wl].push_back(wd);
`ifdef LANE_FIFO_DROP_CNT_EN
    if (wen && !ewa && dropm[wl] < 65535) dropm[wl]++;
`endif
    if (fl) begin
      mq[fll].delete();
      dropm[fll] = 0;
    end
    @(posedge clk); #1;
    cycle_n++;
  endtask

  task automatic wr(input logic [LB-1:0] l, input logic [DW-1:0] d);
    cyc(1'b1, l, d, 1'b0, '0);
  endtask
  task automatic rd(input logic [LB-1:0] l);
    cyc(1'b0, '0, '0, 1'b1, l);
  endtask
  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      mq[i].delete();
      dropm[i] = 0;
    end
    sb.delete();
  endtask

  task automatic reset_checks();
    chk("rst_empty", 64'(lane_empty), 64'hF);
    chk("rst_full", 64'(lane_full), 64'h0);
    chk("rst_afull", 64'(lane_afull), 64'h0);
    chk("rst_usedw", 64'(lane_usedw), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 0; rd_req = 0; flush = 0;
    wr_lane = '0; rd_lane = '0; flush_lane = '0; drop_sel = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    chk("rst_rd_lane", 64'(rd_data_lane), 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read on lane 2.
    wr(2, 40'hA); wr(2, 40'hB); wr(2, 40'hC);
    rd(2); rd(2); rd(2);
    idle(); idle();
    chk("t1_hold_data", 64'(rd_data), 64'hC);
    chk("t1_hold_lane", 64'(rd_data_lane), 64'd2);
    chk("t1_empty2", 64'(lane_empty[2]), 64'd1);

    // Fill lane 1 to full, then try one more write, then drain.
    for (int i = 0; i < DEPTH; i++) wr(1, 40'h10_0000_0000 + 40'(i));
    wr(1, 40'hDEAD);
    chk("t2_full1", 64'(lane_full[1]), 64'd1);
    for (int i = 0; i < DEPTH; i++) rd(1);
    idle();
    // These writes land after the pointers have wrapped.
    wr(1, 40'h55); wr(1, 40'h66); rd(1); rd(1); idle();

    // Lane 0 is empty: a write and a read in the same cycle. Only the write is taken.
    cyc(1'b1, 0, 40'h77, 1'b1, 0);
    chk("t3_usedw0", 64'(lane_usedw[0 +: AW+1]), 64'd1);
    rd(0); idle();

    // Lane 3 is full: a write and a read in the same cycle. Only the read is taken.
    for (int i = 0; i < DEPTH; i++) wr(3, 40'h30_0000_0000 + 40'(i));
    cyc(1'b1, 3, 40'hBAD, 1'b1, 3);
    chk("t4_usedw3", 64'(lane_usedw[3*(AW+1) +: AW+1]), 64'd511);
    chk("t4_full3", 64'(lane_full[3]), 64'd0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 3);

    // Write lane 0 while reading lane 1, interleaved.
    for (int i = 0; i < 100; i++) wr(1, 40'h1100 + 40'(i));
    for (int i = 0; i < 100; i++) cyc(1'b1, 0, 40'h0A00 + 40'(i), 1'b1, 1);
    for (int i = 0; i < 100; i++) rd(0);
    idle();

    // Flush lane 2 together with a write to it. Lane 1 must keep its contents.
    for (int i = 0; i < 5; i++) wr(1, 40'h1B00 + 40'(i));
    for (int i = 0; i < 10; i++) wr(2, 40'h2C00 + 40'(i));
    rd(2);                                       // this word is still delivered
    cyc(1'b1, 2, 40'hFEED, 1'b0, '0, 1'b1, 2);
    chk("t6_usedw2", 64'(lane_usedw[2*(AW+1) +: AW+1]), 64'd0);
    chk("t6_empty2", 64'(lane_empty[2]), 64'd1);
    for (int i = 0; i < 5; i++) rd(1);
    idle();

    // Reset in the middle of a burst. The in-flight read result is lost.
    wr(0, 40'h1); wr(3, 40'h2); wr(0, 40'h3);
    rd(0);
    reset_n = 1'b0;
    #1;
    model_reset();
    reset_checks();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    idle();
    wr(2, 40'h99); rd(2); idle(); idle();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
